// File: rtl/sub32_seq_if.sv
// Handshake and result bundle for the nibble-serial subtractor.
// Under SUB32_SEQ_CMP_EN the bundle also carries the slt/sltu compare outputs.
interface sub32_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             borrow;
    logic             ovf;
    logic             zero;
`ifdef SUB32_SEQ_CMP_EN
    logic             slt;
    logic             sltu;

    modport master (output start, a, b,
                    input  busy, done, d, borrow, ovf, zero, slt, sltu);
    modport slave  (input  start, a, b,
                    output busy, done, d, borrow, ovf, zero, slt, sltu);
`else
    modport master (output start, a, b,
                    input  busy, done, d, borrow, ovf, zero);
    modport slave  (input  start, a, b,
                    output busy, done, d, borrow, ovf, zero);
`endif
endinterface

// File: rtl/sub32_seq.sv
// Multi-cycle subtractor: a - b as a + ~b + 1, one nibble per clock, borrow chained in cy_q.
// Optional SUB32_SEQ_CMP_EN adds registered slt/sltu outputs.
module sub32_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    sub32_seq_if.slave bus
);
    localparam int NIBS = WIDTH / 4;
    localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] dw_q, dw_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
`ifdef SUB32_SEQ_CMP_EN
    logic             slt_q, slt_d;
    logic             sltu_q, sltu_d;
`endif

    logic [3:0]       a_nib, b_nib;
    logic [4:0]       sum5;
    logic [WIDTH-1:0] d_new;
    logic             ovf_new;

    // Current nibble slice; d_new is the working result with this nibble merged in.
    always_comb begin
        a_nib   = a_q[{cnt_q, 2'b00} +: 4];
        b_nib   = b_q[{cnt_q, 2'b00} +: 4];
        sum5    = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, cy_q};
        d_new   = dw_q;
        d_new[{cnt_q, 2'b00} +: 4] = sum5[3:0];
        ovf_new = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_new[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        dw_d     = dw_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef SUB32_SEQ_CMP_EN
        slt_d    = slt_q;
        sltu_d   = sltu_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cy_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                dw_d  = d_new;
                cy_d  = sum5[4];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    d_d      = d_new;
                    borrow_d = ~sum5[4];
                    ovf_d    = ovf_new;
                    zero_d   = (d_new == '0);
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
`ifdef SUB32_SEQ_CMP_EN
                    slt_d    = d_new[WIDTH-1] ^ ovf_new;
                    sltu_d   = ~sum5[4];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            dw_q     <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB32_SEQ_CMP_EN
            slt_q    <= 1'b0;
            sltu_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dw_q     <= dw_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifdef SUB32_SEQ_CMP_EN
            slt_q    <= slt_d;
            sltu_q   <= sltu_d;
`endif
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;
    assign bus.d      = d_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
`ifdef SUB32_SEQ_CMP_EN
    assign bus.slt    = slt_q;
    assign bus.sltu   = sltu_q;
`endif
endmodule

// File: tb/tb_sub32_seq.sv
// Directed bench for sub32_seq: expected results queued at launch, checked when done pulses.
module tb_sub32_seq;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sub32_seq_if #(.WIDTH(W)) bus ();
    sub32_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         borrow;
        logic         ovf;
        logic         zero;
        logic         slt;
        logic         sltu;
    } exp_t;

    exp_t sb[$];
    int   nvec  = 0;
    int   nerr  = 0;
    int   ndone = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference computed with plain integer arithmetic (wide signed difference for overflow).
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t          e;
        logic signed [W:0] sd;
        sd       = $signed({a[W-1], a}) - $signed({b[W-1], b});
        e.d      = a - b;
        e.borrow = (a < b);
        e.ovf    = (sd[W] != sd[W-1]);
        e.zero   = (e.d == '0);
        e.slt    = ($signed(a) < $signed(b));
        e.sltu   = (a < b);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            ndone++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("d",      64'(bus.d),      64'(e.d));
                chk("borrow", 64'(bus.borrow), 64'(e.borrow));
                chk("ovf",    64'(bus.ovf),    64'(e.ovf));
                chk("zero",   64'(bus.zero),   64'(e.zero));
`ifdef SUB32_SEQ_CMP_EN
                chk("slt",    64'(bus.slt),    64'(e.slt));
                chk("sltu",   64'(bus.sltu),   64'(e.sltu));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (push) sb.push_back(model(a, b));
        step();
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'(1));
    endtask

    // Counts edges until done is seen; an expired bound shows up as a latency mismatch.
    task automatic wait_done(input string tag, input int lat);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        chk(tag, 64'(n), 64'(lat));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},   64'(bus.busy),   64'(0));
        chk({tag, "_done"},   64'(bus.done),   64'(0));
        chk({tag, "_d"},      64'(bus.d),      64'(0));
        chk({tag, "_borrow"}, 64'(bus.borrow), 64'(0));
        chk({tag, "_ovf"},    64'(bus.ovf),    64'(0));
        chk({tag, "_zero"},   64'(bus.zero),   64'(0));
`ifdef SUB32_SEQ_CMP_EN
        chk({tag, "_slt"},    64'(bus.slt),    64'(0));
        chk({tag, "_sltu"},   64'(bus.sltu),   64'(0));
`endif
    endtask

    initial begin
        int nd;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (3) step();
        check_cleared("reset");
        reset = 1'b0;
        step();

        launch(32'd5, 32'd3, 1'b1);
        wait_done("lat_5_3", 8);
        step();
        chk("done_pulse", 64'(bus.done), 64'(0));
        repeat (3) step();
        chk("d_hold_idle", 64'(bus.d), 64'(32'h0000_0002));

        launch(32'd3, 32'd5, 1'b1);
        wait_done("lat_3_5", 8);
        step();

        launch(32'h8000_0000, 32'h0000_0001, 1'b1);
        wait_done("lat_ovf", 8);
        step();

        launch(32'h1234_5678, 32'h1234_5678, 1'b1);
        wait_done("lat_eq", 8);
        launch(32'd0, 32'd1, 1'b1);
        wait_done("lat_b2b", 8);
        step();

        // start and operand changes while busy must not disturb the running op
        nd = ndone;
        launch(32'd10, 32'd4, 1'b1);
        repeat (3) step();
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd1;
        step();
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0F0F_0F0F;
        step();
        bus.start = 1'b0;
        wait_done("lat_ignore", 3);
        repeat (10) step();
        chk("single_done", 64'(ndone - nd), 64'(1));

        // reset mid-RUN abandons the op without a done pulse
        launch(32'd9, 32'd2, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        step();
        check_cleared("midrun");
        reset = 1'b0;
        nd = ndone;
        repeat (12) step();
        chk("no_done_after_reset", 64'(ndone - nd), 64'(0));

        launch(32'd9, 32'd2, 1'b1);
        wait_done("lat_after_reset", 8);
        step();
        step();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
